// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_NORMAL    = 0;
    localparam int FIFO_SHOWAHEAD = 1;

    // Ceiling log2 for any positive integer, not only powers of two.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage: one synchronous write port, one read port that is
// either a registered enabled read (normal mode) or an asynchronous read (show-ahead).
module fifo_ram_sdp
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    parameter  int MODE  = FIFO_NORMAL,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read data for normal mode, flushed to zero by reset or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (clr) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = (MODE == FIFO_SHOWAHEAD) ? mem[raddr_i] : rdata_q;

endmodule

// File: rtl/fifo_syn_param.sv
// Parametrised single-clock FIFO with any depth, normal or show-ahead reads,
// programmable almost-full/almost-empty levels, flush and sticky error flags.
module fifo_syn_param
    import fifo_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 16,
    parameter  int SHOW_AHEAD = FIFO_NORMAL,
    parameter  int AF_LEVEL   = 14,
    parameter  int AE_LEVEL   = 2,
    localparam int AW         = clog2(DEPTH),
    localparam int CW         = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    usedw,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("fifo_syn_param: DEPTH must be at least 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("fifo_syn_param: AF_LEVEL must lie in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $error("fifo_syn_param: AE_LEVEL must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             wr_acc_s, rd_acc_s;
    logic             ram_we_s, ram_re_s;
    logic [WIDTH-1:0] ram_rdata_s;

    // Modulo-DEPTH increment; works for non-power-of-two depths.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign usedw        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Acceptance: a full FIFO still takes a write when a read frees a slot.
    always_comb begin
        rd_acc_s = rd & ~empty;
        wr_acc_s = wr & (~full | rd_acc_s);
        ram_we_s = wr_acc_s & ~clr;
        ram_re_s = rd_acc_s & ~clr;
    end

    // Next-state for pointers, count and sticky flags; flush wins over traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (wr_acc_s && !rd_acc_s) begin
                count_d = count_q + CW'(1);
            end else if (rd_acc_s && !wr_acc_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
            if (wr && !wr_acc_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (rd && !rd_acc_s) begin
                udf_d = 1'b1;
            end else begin
                udf_d = udf_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .MODE  (SHOW_AHEAD)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .we_i    (ram_we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (data),
        .re_i    (ram_re_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata_s)
    );

    // Show-ahead presents zero while empty; normal mode passes the registered read.
    always_comb begin
        if ((SHOW_AHEAD == FIFO_SHOWAHEAD) && empty) begin
            q = '0;
        end else begin
            q = ram_rdata_s;
        end
    end

endmodule

// File: tb/tb_fifo_syn_param.sv
// Scoreboard bench: three FIFO instances (DEPTH 5 normal, DEPTH 4 show-ahead,
// DEPTH 4 normal with AF=3/AE=1) share one stimulus bus.
module tb_fifo_syn_param;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst, clr, wr, rd;
    logic [7:0] data;

    logic [7:0] a_q, b_q, c_q;
    logic [2:0] a_usedw, b_usedw, c_usedw;
    logic a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic c_full, c_empty, c_af, c_ae, c_ovf, c_udf;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    fifo_syn_param #(.WIDTH(8), .DEPTH(5), .SHOW_AHEAD(FIFO_NORMAL), .AF_LEVEL(4), .AE_LEVEL(1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .data(data), .q(a_q),
        .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .usedw(a_usedw), .overflow(a_ovf), .underflow(a_udf));

    fifo_syn_param #(.WIDTH(8), .DEPTH(4), .SHOW_AHEAD(FIFO_SHOWAHEAD), .AF_LEVEL(3), .AE_LEVEL(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .data(data), .q(b_q),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .usedw(b_usedw), .overflow(b_ovf), .underflow(b_udf));

    fifo_syn_param #(.WIDTH(8), .DEPTH(4), .SHOW_AHEAD(FIFO_NORMAL), .AF_LEVEL(3), .AE_LEVEL(1)) dut_c (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .data(data), .q(c_q),
        .full(c_full), .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae),
        .usedw(c_usedw), .overflow(c_ovf), .underflow(c_udf));

    // One clock cycle: inputs applied at the falling edge, outputs settled by the next one.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr = w; rd = r; data = d;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        clr = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; data = 8'h00;
        @(negedge clk);
        checks++; if (a_q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", a_q); end
        checks++; if (a_usedw !== 3'd0) begin errors++; $display("FAIL reset_usedw: got %0d want 0", a_usedw); end
        checks++; if ({a_empty, a_full, a_ae, a_af, a_ovf, a_udf} !== 6'b101000) begin
            errors++; $display("FAIL reset_flags: got %b want 101000", {a_empty, a_full, a_ae, a_af, a_ovf, a_udf}); end
        checks++; if ({b_q, b_empty} !== 9'h001) begin errors++; $display("FAIL reset_sa: got %h want 001", {b_q, b_empty}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h11 * i));
            sb.push_back(8'(8'h11 * i));
        end
        cyc(1'b1, 1'b0, 8'h66);
        checks++; if ({a_full, a_usedw, a_ovf} !== 5'b1_101_1) begin
            errors++; $display("FAIL fill_full: got full=%b usedw=%0d ovf=%b want 1 5 1", a_full, a_usedw, a_ovf); end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            exp_d = sb.pop_front();
            checks++; if (a_q !== exp_d) begin errors++; $display("FAIL drain_q: got %h want %h", a_q, exp_d); end
        end
        checks++; if ({a_empty, a_usedw} !== 4'b1_000) begin
            errors++; $display("FAIL drain_empty: got empty=%b usedw=%0d want 1 0", a_empty, a_usedw); end
    endtask

    task automatic test_wrap();
        flush();
        for (int i = 1; i <= 3; i++) begin cyc(1'b1, 1'b0, 8'(i)); sb.push_back(8'(i)); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            exp_d = sb.pop_front();
            checks++; if (a_q !== exp_d) begin errors++; $display("FAIL wrap_pre_q: got %h want %h", a_q, exp_d); end
        end
        for (int i = 1; i <= 4; i++) begin cyc(1'b1, 1'b0, 8'(8'hA0 + i)); sb.push_back(8'(8'hA0 + i)); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            exp_d = sb.pop_front();
            checks++; if (a_q !== exp_d) begin errors++; $display("FAIL wrap_q: got %h want %h", a_q, exp_d); end
        end
    endtask

    task automatic test_full_rw();
        flush();
        for (int i = 1; i <= 5; i++) begin cyc(1'b1, 1'b0, 8'(8'hB0 + i)); sb.push_back(8'(8'hB0 + i)); end
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b1, 8'(8'hC0 + i));
            sb.push_back(8'(8'hC0 + i));
            exp_d = sb.pop_front();
            checks++; if (a_q !== exp_d) begin errors++; $display("FAIL fullrw_q: got %h want %h", a_q, exp_d); end
            checks++; if ({a_full, a_usedw} !== 4'b1_101) begin
                errors++; $display("FAIL fullrw_level: got full=%b usedw=%0d want 1 5", a_full, a_usedw); end
        end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL fullrw_ovf: got %b want 0", a_ovf); end
        while (sb.size() > 0) begin
            cyc(1'b0, 1'b1, 8'h00);
            exp_d = sb.pop_front();
            checks++; if (a_q !== exp_d) begin errors++; $display("FAIL fullrw_drain: got %h want %h", a_q, exp_d); end
        end
    endtask

    task automatic test_empty_rw();
        flush();
        cyc(1'b1, 1'b0, 8'h5A);
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if (a_q !== 8'h5A) begin errors++; $display("FAIL emptyrw_pre: got %h want 5a", a_q); end
        cyc(1'b1, 1'b1, 8'h77);
        checks++; if ({a_udf, a_usedw} !== 4'b1_001) begin
            errors++; $display("FAIL emptyrw_flags: got udf=%b usedw=%0d want 1 1", a_udf, a_usedw); end
        checks++; if (a_q !== 8'h5A) begin errors++; $display("FAIL emptyrw_hold: got %h want 5a", a_q); end
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if (a_q !== 8'h77) begin errors++; $display("FAIL emptyrw_next: got %h want 77", a_q); end
    endtask

    task automatic test_show_ahead();
        flush();
        cyc(1'b1, 1'b0, 8'h3C);
        checks++; if ({b_q, b_empty} !== {8'h3C, 1'b0}) begin
            errors++; $display("FAIL sa_first: got q=%h empty=%b want 3c 0", b_q, b_empty); end
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if ({b_q, b_empty} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL sa_pop: got q=%h empty=%b want 00 1", b_q, b_empty); end
        cyc(1'b1, 1'b0, 8'h10); sb.push_back(8'h10);
        cyc(1'b1, 1'b0, 8'h20); sb.push_back(8'h20);
        while (sb.size() > 0) begin
            exp_d = sb.pop_front();
            checks++; if (b_q !== exp_d) begin errors++; $display("FAIL sa_head: got %h want %h", b_q, exp_d); end
            cyc(1'b0, 1'b1, 8'h00);
        end
        checks++; if ({b_q, b_empty} !== {8'h00, 1'b1}) begin
            errors++; $display("FAIL sa_drained: got q=%h empty=%b want 00 1", b_q, b_empty); end
    endtask

    task automatic test_thresholds();
        logic e_ae, e_af;
        flush();
        for (int k = 0; k <= 4; k++) begin
            e_ae = (k <= 1) ? 1'b1 : 1'b0;
            e_af = (k >= 3) ? 1'b1 : 1'b0;
            checks++; if ({c_usedw, c_ae, c_af} !== {3'(k), e_ae, e_af}) begin
                errors++; $display("FAIL thr_k%0d: got usedw=%0d ae=%b af=%b want %0d %b %b", k, c_usedw, c_ae, c_af, k, e_ae, e_af); end
            if (k < 4) cyc(1'b1, 1'b0, 8'(k));
        end
        cyc(1'b1, 1'b0, 8'hFF);
        checks++; if (c_ovf !== 1'b1) begin errors++; $display("FAIL thr_ovf: got %b want 1", c_ovf); end
        clr = 1'b1;
        cyc(1'b1, 1'b0, 8'hEE);
        clr = 1'b0;
        checks++; if ({c_usedw, c_empty, c_ovf} !== 5'b000_1_0) begin
            errors++; $display("FAIL clr_state: got usedw=%0d empty=%b ovf=%b want 0 1 0", c_usedw, c_empty, c_ovf); end
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b0, 8'h03);
        cyc(1'b0, 1'b1, 8'h00);
        checks++; if ({c_q, c_usedw} !== {8'h01, 3'd2}) begin
            errors++; $display("FAIL rst_pre: got q=%h usedw=%0d want 01 2", c_q, c_usedw); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({c_q, c_usedw, c_empty, c_full, c_ae, c_af, c_ovf, c_udf} !== {8'h00, 3'd0, 6'b101000}) begin
            errors++; $display("FAIL rst_async: got q=%h usedw=%0d flags=%b want 00 0 101000",
                c_q, c_usedw, {c_empty, c_full, c_ae, c_af, c_ovf, c_udf}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_rw();
        test_empty_rw();
        test_show_ahead();
        test_thresholds();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_syn_param.md
Name: fifo_syn_param

Overview:
Parametrised synchronous single-clock FIFO. It is the next-generation replacement for the team's fixed 8x8 synchronous FIFO.
- Supports any depth (not only 2^n) and any width.
- Selectable normal or show-ahead read mode.
- Programmable almost-full and almost-empty thresholds.
- Synchronous flush, plus sticky overflow and underflow error flags.
- Sits between the producer and consumer datapaths inside one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage words (>=2, any integer)
SHOW_AHEAD, 0, 0 = normal read (q valid 1 cycle after rd); 1 = show-ahead (head word on q while !empty, rd pops)
AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
clr  in  1  synchronous flush, active-high
wr  in  1  write request
rd  in  1  read request
data  in  WIDTH  write data
q  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
usedw  out  CW  words stored, 0..DEPTH inclusive; CW = clog2(DEPTH+1)
overflow  out  1  sticky: a write was refused
underflow  out  1  sticky: a read was refused

Behaviour:
- Reset and clock: one clock domain (clk); reset is asynchronous and active-high (rst).
- Reset values: q=0, usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Memory contents are not reset.
- State: wr_ptr and rd_ptr of width AW=clog2(DEPTH), plus count (CW bits).
  - Pointers increment modulo DEPTH: DEPTH-1 wraps to 0.
  - No power-of-2 assumption and no MSB-wrap trick.
- Acceptance rules:
  - wr_acc = wr & (!full | rd_acc).
  - rd_acc = rd & !empty.
- Simultaneous events:
  - Full with wr & rd: both accepted, count stays DEPTH.
  - Empty with wr & rd: only the write is accepted, count becomes 1.
- count next value: +1 on wr_acc only, -1 on rd_acc only, unchanged otherwise.
  - Never exceeds DEPTH, never goes below 0.
  - usedw = count, so usedw reads DEPTH when full.
- All status flags decode the registered count. They change on the same edge as usedw, with no extra lag.
- Normal mode (SHOW_AHEAD=0):
  - On rd_acc, q <= mem[rd_ptr] at that edge; read latency is 1 cycle.
  - q holds its value otherwise, including on a refused read.
- Show-ahead mode (SHOW_AHEAD=1):
  - q = mem[rd_ptr] while !empty; q = 0 while empty.
  - A word written at edge N is on q right after edge N if the FIFO was empty.
  - rd_acc advances to the next word at the next edge.
- Write-then-read of the same slot: read data always comes from committed storage. A word written at edge N is readable from edge N onward.
- Sticky error flags:
  - overflow <= 1 when wr & !wr_acc.
  - underflow <= 1 when rd & !rd_acc.
  - Cleared only by rst or clr.
- clr (flush):
  - Synchronous; highest priority, overriding same-cycle wr/rd.
  - Pointers and count go to 0; q goes to 0; overflow and underflow clear.
  - Memory is untouched.
- rst asserted mid-operation: all state returns to reset values immediately, independent of clk. Data in flight is lost.
- Elaboration-time error on illegal parameters:
  - DEPTH < 2.
  - AF_LEVEL outside 1..DEPTH.
  - AE_LEVEL outside 0..DEPTH-1.

Decomposition:
- Package fifo_pkg contains:
  - clog2 function, valid for any integer including non-2^n.
  - Mode constants FIFO_NORMAL=0 and FIFO_SHOWAHEAD=1.
- One sub-module: fifo_ram_sdp (WIDTH, DEPTH).
  - One synchronous write port.
  - One read port: registered-enable for normal mode, asynchronous for show-ahead mode.
- Pointer, count and flag logic stay in fifo_syn_param.

Test Plan:
- DEPTH=5, SHOW_AHEAD=0: write 0x11..0x55 over 5 cycles, then 1 extra write.
  - Required: full=1, usedw=5, overflow=1.
  - Then 5 reads return 0x11..0x55 in order, each 1 cycle after rd.
  - After the last read: empty=1, usedw=0.
- Wrap-around, DEPTH=5: 3 writes, 3 reads, then 4 writes (0xA1..0xA4) and 4 reads.
  - Required: data returns 0xA1..0xA4 with no corruption across the pointer wrap 4->0.
- Full with simultaneous wr=rd=1 for 3 cycles.
  - Required: usedw stays 5, full stays 1, no overflow, output order preserved.
- Empty with wr=rd=1 on data 0x77.
  - Required: underflow=1, usedw=1, q unchanged.
  - The next read returns 0x77.
- SHOW_AHEAD=1, DEPTH=4: write 0x3C to an empty FIFO.
  - Required: q=0x3C the cycle after the write, before any rd.
  - rd pops; empty=1 and q=0 the next cycle.
- AF_LEVEL=3, AE_LEVEL=1, DEPTH=4: fill one word at a time.
  - Required: almost_empty=1 at counts 0 and 1, deasserting at 2; almost_full=1 at counts 3 and 4.
  - Then clr with wr=1: usedw=0, empty=1, overflow=0, and the write is ignored.
  - Then rst pulse mid-fill: all outputs return to their reset values asynchronously.
